// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters for a two-slot fetch.
// Combinational lookup of PC and PC+4; training from BRU resolutions with a registered redirect.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - 2 - IDX_W
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_fetch_pc,
    output logic        o_pred_taken,
    output logic        o_pred_slot,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_branch_cnt,
    output logic [31:0] o_mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [31:0]      slot1_pc;
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;
    logic [TAG_W-1:0] tag0;
    logic [TAG_W-1:0] tag1;
    logic             hit0;
    logic             hit1;
    logic             taken0;
    logic             taken1;

    assign slot1_pc = i_fetch_pc + 32'd4;
    assign idx0     = i_fetch_pc[IDX_W+1:2];
    assign idx1     = slot1_pc[IDX_W+1:2];
    assign tag0     = i_fetch_pc[31:IDX_W+2];
    assign tag1     = slot1_pc[31:IDX_W+2];
    assign hit0     = valid_q[idx0] && (tag_q[idx0] == tag0);
    assign hit1     = valid_q[idx1] && (tag_q[idx1] == tag1);
    assign taken0   = hit0 && ctr_q[idx0][1];
    assign taken1   = hit1 && ctr_q[idx1][1];

    // Slot 0 wins whenever both fetch slots would be predicted taken.
    always_comb begin
        o_pred_taken  = 1'b0;
        o_pred_slot   = 1'b0;
        o_pred_target = 32'd0;
        if (taken0) begin
            o_pred_taken  = 1'b1;
            o_pred_target = target_q[idx0];
        end else if (taken1) begin
            o_pred_taken  = 1'b1;
            o_pred_slot   = 1'b1;
            o_pred_target = target_q[idx1];
        end
    end

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       upd_ctr;
    logic [1:0]       ctr_next;
    logic             upd_write;
    logic             mispred;
    logic [31:0]      redirect;

    assign upd_idx   = i_upd_pc[IDX_W+1:2];
    assign upd_tag   = i_upd_pc[31:IDX_W+2];
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_ctr   = ctr_q[upd_idx];
    assign upd_write = i_upd_valid && (upd_hit || i_upd_taken);
    assign mispred   = (i_upd_taken != i_upd_pred_taken) ||
                       (i_upd_taken && (i_upd_target != i_upd_pred_target));
    assign redirect  = i_upd_taken ? i_upd_target : (i_upd_pc + 32'd4);

    always_comb begin
        ctr_next = upd_ctr;
        if (i_upd_taken) begin
            if (upd_ctr != 2'b11) ctr_next = upd_ctr + 2'b01;
        end else begin
            if (upd_ctr != 2'b00) ctr_next = upd_ctr - 2'b01;
        end
    end

    // Entry payload needs no reset: a cleared valid bit hides stale contents.
    always_ff @(posedge i_clk) begin
        if (upd_write) begin
            tag_q[upd_idx] <= upd_tag;
            ctr_q[upd_idx] <= upd_hit ? ctr_next : 2'b10;
            if (i_upd_taken) target_q[upd_idx] <= i_upd_target;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
        end else if (i_upd_valid && i_upd_taken && !upd_hit) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mispredict  <= 1'b0;
            o_redirect_pc <= 32'd0;
            o_branch_cnt  <= 32'd0;
            o_mispred_cnt <= 32'd0;
        end else begin
            o_mispredict <= i_upd_valid && mispred;
            if (i_upd_valid && mispred) o_redirect_pc <= redirect;
            if (i_upd_valid && (o_branch_cnt != 32'hFFFF_FFFF))
                o_branch_cnt <= o_branch_cnt + 32'd1;
            if (i_upd_valid && mispred && (o_mispred_cnt != 32'hFFFF_FFFF))
                o_mispred_cnt <= o_mispred_cnt + 32'd1;
        end
    end

    // Byte-offset bits never select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_fetch_pc[1:0], slot1_pc[1:0], i_upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: scoreboard for registered redirect/statistics,
// inline checks for the combinational two-slot prediction.
module tb_branch_predictor;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_fetch_pc;
    logic        o_pred_taken;
    logic        o_pred_slot;
    logic [31:0] o_pred_target;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic        i_upd_pred_taken;
    logic [31:0] i_upd_pred_target;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_branch_cnt;
    logic [31:0] o_mispred_cnt;

    branch_predictor dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_fetch_pc        (i_fetch_pc),
        .o_pred_taken      (o_pred_taken),
        .o_pred_slot       (o_pred_slot),
        .o_pred_target     (o_pred_target),
        .i_upd_valid       (i_upd_valid),
        .i_upd_pc          (i_upd_pc),
        .i_upd_taken       (i_upd_taken),
        .i_upd_target      (i_upd_target),
        .i_upd_pred_taken  (i_upd_pred_taken),
        .i_upd_pred_target (i_upd_pred_target),
        .o_mispredict      (o_mispredict),
        .o_redirect_pc     (o_redirect_pc),
        .o_branch_cnt      (o_branch_cnt),
        .o_mispred_cnt     (o_mispred_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        mis;
        logic [31:0] redirect;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_branch = 0;
    logic [31:0] exp_mis = 0;
    logic [31:0] exp_redirect = 0;
    logic [31:0] mon_redirect = 0;
    logic [31:0] mon_bcnt = 0;
    logic [31:0] mon_mcnt = 0;
    logic        sv;
    logic        sr;

    // Every clock edge outside reset is scored: a popped expectation if an update was
    // sampled, otherwise no pulse and unchanged redirect/statistics.
    initial begin
        forever begin
            @(posedge i_clk);
            sv = i_upd_valid;
            sr = i_rst;
            #1;
            if (!sr && !i_rst) begin
                if (sv) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL sb_underflow: got update with no expectation queued");
                    end else begin
                        e = sb.pop_front();
                        if ({o_mispredict, o_redirect_pc, o_branch_cnt, o_mispred_cnt} !== e) begin
                            errors++;
                            $display("[TB] FAIL update_result: got mis=%b redir=%h bc=%0d mc=%0d want mis=%b redir=%h bc=%0d mc=%0d",
                                     o_mispredict, o_redirect_pc, o_branch_cnt, o_mispred_cnt,
                                     e.mis, e.redirect, e.bcnt, e.mcnt);
                        end
                        mon_redirect = e.redirect;
                        mon_bcnt     = e.bcnt;
                        mon_mcnt     = e.mcnt;
                    end
                end else begin
                    checks++;
                    if ({o_mispredict, o_redirect_pc, o_branch_cnt, o_mispred_cnt} !==
                        {1'b0, mon_redirect, mon_bcnt, mon_mcnt}) begin
                        errors++;
                        $display("[TB] FAIL idle_hold: got mis=%b redir=%h bc=%0d mc=%0d want mis=0 redir=%h bc=%0d mc=%0d",
                                 o_mispredict, o_redirect_pc, o_branch_cnt, o_mispred_cnt,
                                 mon_redirect, mon_bcnt, mon_mcnt);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_model();
        sb.delete();
        exp_branch   = 0;
        exp_mis      = 0;
        exp_redirect = 0;
        mon_redirect = 0;
        mon_bcnt     = 0;
        mon_mcnt     = 0;
    endtask

    task automatic send_update(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                               input logic pred_taken, input logic [31:0] pred_target);
        logic mis;
        @(negedge i_clk);
        i_upd_valid       = 1'b1;
        i_upd_pc          = pc;
        i_upd_taken       = taken;
        i_upd_target      = target;
        i_upd_pred_taken  = pred_taken;
        i_upd_pred_target = pred_target;
        mis = (taken != pred_taken) || (taken && (target != pred_target));
        if (exp_branch != 32'hFFFF_FFFF) exp_branch++;
        if (mis) begin
            if (exp_mis != 32'hFFFF_FFFF) exp_mis++;
            exp_redirect = taken ? target : pc + 32'd4;
        end
        sb.push_back('{mis: mis, redirect: exp_redirect, bcnt: exp_branch, mcnt: exp_mis});
        @(posedge i_clk);
        #1;
        i_upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_fetch_pc = 32'h100;
        i_upd_valid = 1'b0;
        i_upd_pc = 0; i_upd_taken = 0; i_upd_target = 0;
        i_upd_pred_taken = 0; i_upd_pred_target = 0;
        clear_model();
        repeat (3) @(posedge i_clk);
        #2;
        checks++;
        if ({o_mispredict, o_redirect_pc, o_branch_cnt, o_mispred_cnt} !== 97'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got mis=%b redir=%h bc=%0d mc=%0d want all 0",
                     o_mispredict, o_redirect_pc, o_branch_cnt, o_mispred_cnt);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL cold_fetch: got %b/%b/%h want 0/0/00000000", o_pred_taken, o_pred_slot, o_pred_target);
        end
    endtask

    task automatic test_cold_miss();
        send_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        i_fetch_pc = 32'h100; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b1, 1'b0, 32'h200}) begin
            errors++;
            $display("[TB] FAIL cold_refetch: got %b/%b/%h want 1/0/00000200", o_pred_taken, o_pred_slot, o_pred_target);
        end
    endtask

    task automatic test_hysteresis();
        send_update(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        i_fetch_pc = 32'h100; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL hyst_weak_nt: got %b/%b/%h want 0/0/00000000", o_pred_taken, o_pred_slot, o_pred_target);
        end
        send_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        i_fetch_pc = 32'h100; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b1, 1'b0, 32'h200}) begin
            errors++;
            $display("[TB] FAIL hyst_weak_t: got %b/%b/%h want 1/0/00000200", o_pred_taken, o_pred_slot, o_pred_target);
        end
        for (int i = 0; i < 3; i++) send_update(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        // A saturated counter survives one not-taken and still predicts taken.
        send_update(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        i_fetch_pc = 32'h100; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b1, 1'b0, 32'h200}) begin
            errors++;
            $display("[TB] FAIL hyst_saturate: got %b/%b/%h want 1/0/00000200", o_pred_taken, o_pred_slot, o_pred_target);
        end
    endtask

    task automatic test_target_mismatch();
        send_update(32'h100, 1'b1, 32'h240, 1'b1, 32'h200);
        i_fetch_pc = 32'h100; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b1, 1'b0, 32'h240}) begin
            errors++;
            $display("[TB] FAIL target_update: got %b/%b/%h want 1/0/00000240", o_pred_taken, o_pred_slot, o_pred_target);
        end
    endtask

    task automatic test_alias();
        send_update(32'h1100, 1'b0, 32'h0, 1'b0, 32'h0);
        i_fetch_pc = 32'h100; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b1, 1'b0, 32'h240}) begin
            errors++;
            $display("[TB] FAIL alias_no_alloc: got %b/%b/%h want 1/0/00000240", o_pred_taken, o_pred_slot, o_pred_target);
        end
        send_update(32'h1100, 1'b1, 32'h700, 1'b0, 32'h0);
        i_fetch_pc = 32'h100; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL alias_evicted: got %b/%b/%h want 0/0/00000000", o_pred_taken, o_pred_slot, o_pred_target);
        end
        i_fetch_pc = 32'h1100; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b1, 1'b0, 32'h700}) begin
            errors++;
            $display("[TB] FAIL alias_replaced: got %b/%b/%h want 1/0/00000700", o_pred_taken, o_pred_slot, o_pred_target);
        end
    endtask

    task automatic test_back_to_back();
        send_update(32'h300, 1'b1, 32'h400, 1'b0, 32'h0);
        send_update(32'h304, 1'b1, 32'h500, 1'b0, 32'h0);
        i_fetch_pc = 32'h300; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b1, 1'b0, 32'h400}) begin
            errors++;
            $display("[TB] FAIL slot0_priority: got %b/%b/%h want 1/0/00000400", o_pred_taken, o_pred_slot, o_pred_target);
        end
        send_update(32'h300, 1'b0, 32'h0, 1'b1, 32'h400);
        send_update(32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        i_fetch_pc = 32'h300; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b1, 1'b1, 32'h500}) begin
            errors++;
            $display("[TB] FAIL slot1_fallback: got %b/%b/%h want 1/1/00000500", o_pred_taken, o_pred_slot, o_pred_target);
        end
    endtask

    task automatic test_wrap();
        i_fetch_pc = 32'hFFFF_FFFC; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL wrap_miss: got %b/%b/%h want 0/0/00000000", o_pred_taken, o_pred_slot, o_pred_target);
        end
        send_update(32'h0, 1'b1, 32'h800, 1'b0, 32'h0);
        i_fetch_pc = 32'hFFFF_FFFC; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b1, 1'b1, 32'h800}) begin
            errors++;
            $display("[TB] FAIL wrap_slot1: got %b/%b/%h want 1/1/00000800", o_pred_taken, o_pred_slot, o_pred_target);
        end
        send_update(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h123);
    endtask

    task automatic test_reset_mid();
        send_update(32'h980, 1'b1, 32'hA00, 1'b0, 32'h0);
        i_fetch_pc = 32'h980; #1;
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b1, 1'b0, 32'hA00}) begin
            errors++;
            $display("[TB] FAIL pre_reset_hit: got %b/%b/%h want 1/0/00000a00", o_pred_taken, o_pred_slot, o_pred_target);
        end
        @(negedge i_clk);
        i_upd_valid = 1'b1;
        i_upd_pc = 32'h100; i_upd_taken = 1'b1; i_upd_target = 32'h200;
        i_upd_pred_taken = 1'b0; i_upd_pred_target = 32'h0;
        #2;
        i_rst = 1'b1;
        clear_model();
        #1;
        checks++;
        if ({o_mispredict, o_redirect_pc, o_branch_cnt, o_mispred_cnt} !== 97'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got mis=%b redir=%h bc=%0d mc=%0d want all 0",
                     o_mispredict, o_redirect_pc, o_branch_cnt, o_mispred_cnt);
        end
        checks++;
        if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL async_reset_lookup: got %b/%b/%h want 0/0/00000000", o_pred_taken, o_pred_slot, o_pred_target);
        end
        @(posedge i_clk);
        #1;
        i_upd_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            i_fetch_pc = (k == 0) ? 32'h100 : 32'h980;
            #1;
            checks++;
            if ({o_pred_taken, o_pred_slot, o_pred_target} !== {1'b0, 1'b0, 32'h0}) begin
                errors++;
                $display("[TB] FAIL post_reset_lookup: pc=%h got %b/%b/%h want 0/0/00000000",
                         i_fetch_pc, o_pred_taken, o_pred_slot, o_pred_target);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hysteresis();
        test_target_mismatch();
        test_alias();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        repeat (2) @(posedge i_clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters for the 2-issue front end. It predicts the two fetch slots (PC, PC+4) combinationally each cycle. It is trained by branch resolutions from the BRU (taken/target). On a resolution it emits a registered one-cycle mispredict/redirect pulse to fetch and keeps saturating branch and mispredict statistics counters.

## Interface
- IDX_W, 6, index width; BTB holds 2**IDX_W entries indexed by pc[IDX_W+1:2]
- TAG_W, 32-2-IDX_W, tag width; tag = pc[31:IDX_W+2]
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_fetch_pc  in  32  PC of fetch slot 0; slot 1 is i_fetch_pc+4
- o_pred_taken  out  1  a slot is predicted taken (combinational)
- o_pred_slot  out  1  slot predicted taken (0/1); 0 when o_pred_taken=0
- o_pred_target  out  32  predicted target; 0 when o_pred_taken=0
- i_upd_valid  in  1  BRU resolution valid this cycle
- i_upd_pc  in  32  PC of resolved branch
- i_upd_taken  in  1  actual outcome (BRU taken)
- i_upd_target  in  32  actual target when taken
- i_upd_pred_taken  in  1  prediction made at fetch for this branch
- i_upd_pred_target  in  32  predicted target made at fetch
- o_mispredict  out  1  registered one-cycle pulse
- o_redirect_pc  out  32  correct fetch PC, valid with o_mispredict
- o_branch_cnt  out  32  resolved branches, saturating
- o_mispred_cnt  out  32  mispredicted branches, saturating

## Operation
- Entry fields: valid, tag[TAG_W-1:0], target[31:0], ctr[1:0] (00 SNT, 01 WNT, 10 WT, 11 ST).
- Lookup, per slot: hit = valid & tag match; slot taken = hit & ctr[1].
- Slot 0 has priority. If slot 0 is taken, output slot 0 and ignore slot 1. Otherwise slot 1 is used if taken. If neither is taken, all prediction outputs are 0.
- Lookup reads the current array state. There is no bypass of a same-cycle update.
- Update on i_upd_valid, entry at index of i_upd_pc:
  - On hit with taken: ctr saturating +1 (11 stays 11), and target <= i_upd_target.
  - On hit with not-taken: ctr saturating −1 (00 stays 00). Target is unchanged.
  - On miss with taken: allocate/replace. Write valid=1, tag, target, ctr=10.
  - On miss with not-taken: no write.
- Mispredict condition: i_upd_taken != i_upd_pred_taken, or (i_upd_taken & i_upd_target != i_upd_pred_target).
- Redirect value: i_upd_taken ? i_upd_target : i_upd_pc+4 (mod 2**32).
- Statistics: o_branch_cnt +1 per valid update. o_mispred_cnt +1 per mispredict. Both counters stop at 32'hFFFFFFFF.
- When i_upd_valid=0, nothing changes, and o_mispredict is 0 on the next cycle.

## Timing
- Prediction: 0-cycle combinational from i_fetch_pc.
- Training: array write at the edge where i_upd_valid=1. The new state is visible to lookups from the following cycle.
- o_mispredict and o_redirect_pc are registered, one cycle after the update is sampled. o_mispredict is a single-cycle pulse. Back-to-back updates give back-to-back pulses.
- o_redirect_pc holds its last value when o_mispredict=0.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits are cleared.
  - o_mispredict=0, o_redirect_pc=0, o_branch_cnt=0, o_mispred_cnt=0.
  - Tag, target and ctr contents are don't-care; valid gates them.
  - An update sampled in the reset cycle is dropped.
- Aliasing: different PCs with the same index and different tag replace the entry only on a taken miss.
- Wrap: i_fetch_pc=32'hFFFFFFFC gives slot 1 PC 0. i_upd_pc=32'hFFFFFFFC not-taken redirects to 0.

## Test plan
- Cold miss: after reset, fetch 0x100 → o_pred_taken=0, slot 0, target 0.
  - Then update pc 0x100, taken, target 0x200, pred_taken=0 → next cycle o_mispredict=1, o_redirect_pc=0x200, counts 1/1.
  - Refetch 0x100 → taken, slot 0, target 0x200.
- Counter hysteresis at 0x100:
  - Update not-taken with pred_taken=1 → ctr 01, refetch predicts not-taken, redirect 0x104.
  - Update taken → ctr 10, predicts taken again.
  - Three further taken updates → ctr stays at 11.
- Slot priority: train 0x300→0x400 and 0x304→0x500.
  - Fetch 0x300 → slot 0, target 0x400.
  - Train 0x300 not-taken twice → fetch 0x300 gives slot 1, target 0x500.
- Target mismatch: with 0x100→0x200 trained, update taken, target 0x240, pred_target 0x200 → mispredict, redirect 0x240, BTB target becomes 0x240.
- Alias and no-allocate:
  - Update 0x1100 not-taken (miss) → no write; 0x100 still hits.
  - Update 0x1100 taken → replaces the entry; fetch 0x100 misses.
- Reset mid-stream: assert i_rst asynchronously between edges during an update → outputs 0 immediately, all lookups miss, counters 0 after release.
